// File: rtl/pipeline_perf_monitor.sv
// Pipeline performance/hazard monitor: cycle and per-event counters, a snapshot bank
// readable via a selector, and a first-word-fall-through timestamped event trace FIFO.
module pipeline_perf_monitor #(
    parameter int unsigned         NUM_EVT     = 8,
    parameter int unsigned         CNT_W       = 32,
    parameter int unsigned         SEL_W       = 5,
    parameter int unsigned         SATURATE    = 0,
    parameter int unsigned         TRACE_DEPTH = 16,
    parameter int unsigned         TS_W        = 16,
    parameter logic [NUM_EVT-1:0]  TRACE_MASK  = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic                      snap_i,
    input  logic [NUM_EVT-1:0]        evt_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [CNT_W-1:0]          cnt_o,
    output logic [NUM_EVT:0]          ovf_o,
    output logic                      trc_valid_o,
    input  logic                      trc_ready_i,
    output logic [TS_W+NUM_EVT-1:0]   trc_data_o,
    output logic                      trc_drop_o,
    output logic [7:0]                drop_cnt_o
);

    localparam int unsigned PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned REC_W = TS_W + NUM_EVT;
    localparam int unsigned OVF_W = NUM_EVT + 1;

    // Live counters and their next values
    logic [CNT_W-1:0]   cyc_cnt, cyc_nxt;
    logic [CNT_W-1:0]   evt_cnt [NUM_EVT];
    logic [CNT_W-1:0]   evt_nxt [NUM_EVT];
    logic               cyc_set;
    logic [NUM_EVT-1:0] evt_set;

    // Shadow bank
    logic [CNT_W-1:0]   sh_cyc;
    logic [CNT_W-1:0]   sh_evt [NUM_EVT];
    logic [OVF_W-1:0]   sh_ovf;
    logic [CNT_W-1:0]   rd_val;

    // Trace FIFO
    logic [REC_W-1:0]   mem [TRACE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [OCC_W-1:0]   occ, occ_nxt;
    logic [REC_W-1:0]   rec, head_nxt;
    logic               push_req, full, pop, do_push, drop;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (v == '1) begin
            return (SATURATE != 0) ? v : '0;
        end
        return v + CNT_W'(1);
    endfunction

    // Counter increment and overflow detection
    always_comb begin
        cyc_nxt = cyc_cnt;
        cyc_set = 1'b0;
        evt_set = '0;
        if (en_i) begin
            cyc_nxt = bump(cyc_cnt);
            cyc_set = (cyc_cnt == '1);
        end
        for (int unsigned k = 0; k < NUM_EVT; k++) begin
            evt_nxt[k] = evt_cnt[k];
            if (en_i && evt_i[k]) begin
                evt_nxt[k] = bump(evt_cnt[k]);
                evt_set[k] = (evt_cnt[k] == '1);
            end
        end
    end

    // Shadow readout mux
    always_comb begin
        rd_val = '0;
        if (sel_i == '0) begin
            rd_val = sh_cyc;
        end
        for (int unsigned k = 0; k < NUM_EVT; k++) begin
            if (sel_i == SEL_W'(k + 1)) begin
                rd_val = sh_evt[k];
            end
        end
        if (sel_i == SEL_W'(NUM_EVT + 1)) begin
            rd_val = CNT_W'(sh_ovf);
        end
    end

    // FIFO control; the head register is precomputed so trc_data_o is a flop
    always_comb begin
        rec      = {TS_W'(cyc_cnt), evt_i};
        push_req = en_i && !clr_i && ((evt_i & TRACE_MASK) != '0);
        full     = (occ == OCC_W'(TRACE_DEPTH));
        pop      = trc_valid_o && trc_ready_i;
        do_push  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        rd_nxt   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_nxt   = do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
        occ_nxt  = occ + OCC_W'(do_push) - OCC_W'(pop);
        head_nxt = '0;
        if (occ_nxt != '0) begin
            head_nxt = (do_push && (wr_ptr == rd_nxt)) ? rec : mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr_i && do_push) begin
            mem[wr_ptr] <= rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt     <= '0;
            sh_cyc      <= '0;
            sh_ovf      <= '0;
            ovf_o       <= '0;
            cnt_o       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            trc_valid_o <= 1'b0;
            trc_data_o  <= '0;
            trc_drop_o  <= 1'b0;
            drop_cnt_o  <= '0;
            for (int unsigned k = 0; k < NUM_EVT; k++) begin
                evt_cnt[k] <= '0;
                sh_evt[k]  <= '0;
            end
        end else begin
            // Shadow captures pre-increment, pre-clear values and is never cleared
            if (snap_i) begin
                sh_cyc <= cyc_cnt;
                sh_evt <= evt_cnt;
                sh_ovf <= ovf_o;
            end
            cnt_o <= rd_val;
            if (clr_i) begin
                cyc_cnt     <= '0;
                ovf_o       <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                occ         <= '0;
                trc_valid_o <= 1'b0;
                trc_data_o  <= '0;
                trc_drop_o  <= 1'b0;
                drop_cnt_o  <= '0;
                for (int unsigned k = 0; k < NUM_EVT; k++) begin
                    evt_cnt[k] <= '0;
                end
            end else begin
                cyc_cnt     <= cyc_nxt;
                evt_cnt     <= evt_nxt;
                ovf_o       <= ovf_o | {evt_set, cyc_set};
                wr_ptr      <= wr_nxt;
                rd_ptr      <= rd_nxt;
                occ         <= occ_nxt;
                trc_valid_o <= (occ_nxt != '0);
                trc_data_o  <= head_nxt;
                if (drop) begin
                    trc_drop_o <= 1'b1;
                    if (drop_cnt_o != 8'hFF) begin
                        drop_cnt_o <= drop_cnt_o + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Scoreboard bench for pipeline_perf_monitor: four instances (default, 4-bit wrap,
// 4-bit saturate, depth-4 FIFO) share stimulus but have their own enables.
module tb_pipeline_perf_monitor;

    localparam int RW = 24;

    logic       clk, rst, clr, snap;
    logic [7:0] evt;
    logic [4:0] sel;
    logic       en0, en_w, en_t, rdy0, rdy_t, rdy_x;

    logic [31:0] cnt0;  logic [8:0] ovf0;  logic v0;  logic [RW-1:0] d0;  logic dr0;  logic [7:0] dc0;
    logic [3:0]  cntw;  logic [8:0] ovfw;  logic vw;  logic [RW-1:0] dw;  logic drw;  logic [7:0] dcw;
    logic [3:0]  cnts;  logic [8:0] ovfs;  logic vs;  logic [RW-1:0] ds;  logic drs;  logic [7:0] dcs;
    logic [31:0] cntt;  logic [8:0] ovft;  logic vt;  logic [RW-1:0] dt;  logic drt;  logic [7:0] dct;

    pipeline_perf_monitor u0 (
        .clk(clk), .rst(rst), .en_i(en0), .clr_i(clr), .snap_i(snap), .evt_i(evt), .sel_i(sel),
        .cnt_o(cnt0), .ovf_o(ovf0), .trc_valid_o(v0), .trc_ready_i(rdy0), .trc_data_o(d0),
        .trc_drop_o(dr0), .drop_cnt_o(dc0));

    pipeline_perf_monitor #(.CNT_W(4), .SATURATE(0)) u_w (
        .clk(clk), .rst(rst), .en_i(en_w), .clr_i(clr), .snap_i(snap), .evt_i(evt), .sel_i(sel),
        .cnt_o(cntw), .ovf_o(ovfw), .trc_valid_o(vw), .trc_ready_i(rdy_x), .trc_data_o(dw),
        .trc_drop_o(drw), .drop_cnt_o(dcw));

    pipeline_perf_monitor #(.CNT_W(4), .SATURATE(1)) u_s (
        .clk(clk), .rst(rst), .en_i(en_w), .clr_i(clr), .snap_i(snap), .evt_i(evt), .sel_i(sel),
        .cnt_o(cnts), .ovf_o(ovfs), .trc_valid_o(vs), .trc_ready_i(rdy_x), .trc_data_o(ds),
        .trc_drop_o(drs), .drop_cnt_o(dcs));

    pipeline_perf_monitor #(.TRACE_DEPTH(4)) u_t (
        .clk(clk), .rst(rst), .en_i(en_t), .clr_i(clr), .snap_i(snap), .evt_i(evt), .sel_i(sel),
        .cnt_o(cntt), .ovf_o(ovft), .trc_valid_o(vt), .trc_ready_i(rdy_t), .trc_data_o(dt),
        .trc_drop_o(drt), .drop_cnt_o(dct));

    typedef struct {
        int          dut;
        logic [31:0] exp;
        string       name;
    } rd_t;

    int            checks = 0;
    int            failures = 0;
    logic [RW-1:0] q0[$];
    logic [RW-1:0] qt[$];
    rd_t           rd_q[$];
    logic          rd_req = 1'b0;
    logic          rd_pend = 1'b0;
    int unsigned   model_cyc0 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Readout monitor: cnt_o is valid one cycle after the selector was sampled
    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        rd_t e;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_underflow", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                case (e.dut)
                    0:       chk(e.name, cnt0, e.exp);
                    1:       chk(e.name, 32'(cntw), e.exp);
                    2:       chk(e.name, 32'(cnts), e.exp);
                    default: chk(e.name, cntt, e.exp);
                endcase
            end
        end
        // Trace monitors: compare on each handshake that will be taken
        if (!rst && !clr && v0 && rdy0) begin
            if (q0.size() == 0) chk("trace0_unexpected", 32'(d0), 32'd0);
            else                chk("trace0", 32'(d0), 32'(q0.pop_front()));
        end
        if (!rst && !clr && vt && rdy_t) begin
            if (qt.size() == 0) chk("trace_t_unexpected", 32'(dt), 32'd0);
            else                chk("trace_t", 32'(dt), 32'(qt.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read(input int dut, input logic [4:0] s, input logic [31:0] exp, input string nm);
        rd_t e;
        sel = s;
        rd_req = 1'b1;
        e.dut = dut;
        e.exp = exp;
        e.name = nm;
        rd_q.push_back(e);
        step();
        rd_req = 1'b0;
    endtask

    // One enabled cycle on u0 with the given events; expected trace record queued
    task automatic ev0(input logic [7:0] e);
        evt = e;
        en0 = 1'b1;
        if (e != 8'h00) q0.push_back({16'(model_cyc0), e});
        model_cyc0++;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clr = 1'b0; snap = 1'b0; evt = '0; sel = '0;
        en0 = 1'b0; en_w = 1'b0; en_t = 1'b0; rdy0 = 1'b0; rdy_t = 1'b0; rdy_x = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_cnt", cnt0, 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_drop_cnt", 32'(dc0), 0);
        chk("rst_drop", 32'(dr0), 0);
        chk("rst_data", 32'(d0), 0);

        // 10 idle counted cycles
        repeat (10) ev0(8'h00);
        en0 = 1'b0; evt = '0; snap = 1'b1; step(); snap = 1'b0;
        read(0, 5'd0, 32'd10, "t1_cyc");
        for (int i = 1; i <= 8; i++) read(0, 5'(i), 32'd0, "t1_evt");
        chk("t1_valid", 32'(v0), 0);

        // evt0 for 5 cycles, evt2 pulsed 3 times (one overlapping) -> 7 records
        ev0(8'h01); ev0(8'h05); ev0(8'h01); ev0(8'h01); ev0(8'h01);
        ev0(8'h00); ev0(8'h04); ev0(8'h00); ev0(8'h04);
        en0 = 1'b0; evt = '0;
        step(); step();
        chk("t2_hold_data", 32'(d0), 32'h000A01);
        chk("t2_valid", 32'(v0), 1);
        chk("t2_qsize", q0.size(), 7);
        snap = 1'b1; step(); snap = 1'b0;
        read(0, 5'd1, 32'd5, "t2_evt0");
        read(0, 5'd3, 32'd3, "t2_evt2");
        read(0, 5'd0, 32'd19, "t2_cyc");
        read(0, 5'd2, 32'd0, "t2_evt1");
        read(0, 5'd9, 32'd0, "t2_ovf_sel");
        read(0, 5'd20, 32'd0, "t2_bad_sel");
        rdy0 = 1'b1;
        repeat (9) step();
        rdy0 = 1'b0;
        chk("t2_drained", q0.size(), 0);
        chk("t2_valid_end", 32'(v0), 0);

        // 4-bit counters: 17 increments wrap to 1 or saturate at 15
        en_w = 1'b1; evt = 8'h02;
        repeat (17) step();
        en_w = 1'b0; evt = '0;
        chk("t3_ovf_wrap", 32'(ovfw), 32'h005);
        chk("t3_ovf_sat", 32'(ovfs), 32'h005);
        snap = 1'b1; step(); snap = 1'b0;
        read(1, 5'd2, 32'd1, "t3_wrap_evt1");
        read(2, 5'd2, 32'd15, "t3_sat_evt1");
        read(1, 5'd0, 32'd1, "t3_wrap_cyc");
        read(2, 5'd0, 32'd15, "t3_sat_cyc");
        read(1, 5'd9, 32'd5, "t3_wrap_ovf_sel");

        // Depth-4 FIFO: 6 pushes without pop -> 2 drops
        en_t = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            evt = 8'(i);
            if (i <= 4) qt.push_back({16'(i - 1), 8'(i)});
            step();
        end
        en_t = 1'b0; evt = '0;
        chk("t4_drop_cnt", 32'(dct), 2);
        chk("t4_drop", 32'(drt), 1);
        chk("t4_valid", 32'(vt), 1);
        // Push with pop while full: no drop
        en_t = 1'b1; evt = 8'h07; rdy_t = 1'b1;
        qt.push_back({16'd6, 8'h07});
        step();
        en_t = 1'b0; evt = '0; rdy_t = 1'b0;
        chk("t4_drop_cnt_hold", 32'(dct), 2);
        rdy_t = 1'b1;
        repeat (6) step();
        rdy_t = 1'b0;
        chk("t4_drained", qt.size(), 0);
        chk("t4_valid_end", 32'(vt), 0);

        // Clear, then 20 counted cycles and a read-and-clear
        clr = 1'b1; step(); clr = 1'b0;
        q0.delete(); model_cyc0 = 0;
        chk("t5_ovf_cleared", 32'(ovfw), 0);
        chk("t5_drop_cnt_cleared", 32'(dct), 0);
        chk("t5_drop_cleared", 32'(drt), 0);
        repeat (18) ev0(8'h00);
        ev0(8'h08); ev0(8'h08);
        en0 = 1'b0; evt = '0;
        chk("t5_valid_pre", 32'(v0), 1);
        snap = 1'b1; clr = 1'b1; step(); snap = 1'b0; clr = 1'b0;
        q0.delete(); model_cyc0 = 0;
        chk("t5_valid_post", 32'(v0), 0);
        chk("t5_ovf_post", 32'(ovf0), 0);
        read(0, 5'd0, 32'd20, "t5_snap_cyc");
        read(0, 5'd4, 32'd2, "t5_snap_evt3");
        snap = 1'b1; step(); snap = 1'b0;
        read(0, 5'd0, 32'd0, "t5_live_cyc");
        read(0, 5'd4, 32'd0, "t5_live_evt3");

        // Reset while FIFOs hold records and a pop is requested
        en_t = 1'b1; evt = 8'h80;
        repeat (3) ev0(8'h80);
        en0 = 1'b0;
        repeat (3) step();
        en_t = 1'b0; evt = '0;
        chk("t6_valid_pre", 32'(v0), 1);
        chk("t6_drop_cnt_pre", 32'(dct), 2);
        snap = 1'b1; step(); snap = 1'b0;
        sel = 5'd0; step();
        chk("t6_cnt_pre", cnt0, 3);
        rdy0 = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; rdy0 = 1'b0;
        q0.delete(); model_cyc0 = 0;
        chk("t6_valid", 32'(v0), 0);
        chk("t6_valid_t", 32'(vt), 0);
        chk("t6_drop_cnt", 32'(dct), 0);
        chk("t6_drop", 32'(drt), 0);
        chk("t6_cnt", cnt0, 0);
        chk("t6_data", 32'(d0), 0);
        read(0, 5'd0, 32'd0, "t6_shadow_cyc");

        step(); step();
        chk("end_rd_queue", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
